// File: rtl/rx_stat_fifo.sv
// Receive-path word FIFO with occupancy count, programmable thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read.
module rx_stat_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_LEVEL);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_acc, rd_acc;

  // Pointers carry an extra wrap bit, so their difference is the exact
  // occupancy 0..DEPTH and every flag comes from registered state only.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];
  assign wr_acc  = wr_en && !full  && !flush && !rst;
  assign rd_acc  = rd_en && !empty && !flush;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE_C;
        rd_data_d  = mem_q[rd_addr];
        rd_valid_d = 1'b1;
      end
    end

    // Clear first so that a same-cycle error event wins over clr_err.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!flush && wr_en && full)  ovf_d = 1'b1;
    if (!flush && rd_en && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; a word is only ever read
  // after it has been written, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so the
      // output is defined out of reset.
      assign rd_data  = empty ? '0 : mem_q[rd_addr];
      assign rd_valid = !empty;
    end else begin : g_reg
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_rx_stat_fifo.sv
// Drives one registered-read and one FWFT instance with identical stimulus
// and compares both against a queue-based model every cycle.
module tb_rx_stat_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, flush, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] r_rd_data, f_rd_data;
  logic          r_rd_valid, f_rd_valid;
  logic          r_full, f_full, r_empty, f_empty;
  logic          r_af, f_af, r_ae, f_ae;
  logic [CW-1:0] r_count, f_count;
  logic          r_ovf, f_ovf, r_unf, f_unf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_q[$];
  bit            m_ovf, m_unf, m_rdv;
  logic [DW-1:0] m_rdd;

  always #5 clk = ~clk;

  rx_stat_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf), .clr_err(clr_err)
  );

  rx_stat_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of stored words plus sticky flags.
  task automatic model_step();
    int  sz;
    bit  set_o, set_u;
    sz = m_q.size();
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else if (flush) begin
      m_q.delete();
      m_rdv = 0;
      if (clr_err) begin m_ovf = 0; m_unf = 0; end
    end else begin
      set_o = wr_en && (sz == DEPTH);
      set_u = rd_en && (sz == 0);
      if (rd_en && sz > 0) begin
        m_rdd = m_q.pop_front();
        m_rdv = 1;
      end else begin
        m_rdv = 0;
      end
      if (wr_en && sz < DEPTH) m_q.push_back(wr_data);
      m_ovf = set_o || (m_ovf && !clr_err);
      m_unf = set_u || (m_unf && !clr_err);
    end
  endtask

  task automatic compare();
    int sz;
    sz = m_q.size();
    check("reg.count", r_count, sz);
    check("reg.full", r_full, sz == DEPTH);
    check("reg.empty", r_empty, sz == 0);
    check("reg.almost_full", r_af, sz >= AF);
    check("reg.almost_empty", r_ae, sz <= AE);
    check("reg.overflow", r_ovf, m_ovf);
    check("reg.underflow", r_unf, m_unf);
    check("reg.rd_valid", r_rd_valid, m_rdv);
    check("reg.rd_data", r_rd_data, m_rdd);
    check("fwft.count", f_count, sz);
    check("fwft.full", f_full, sz == DEPTH);
    check("fwft.empty", f_empty, sz == 0);
    check("fwft.almost_full", f_af, sz >= AF);
    check("fwft.almost_empty", f_ae, sz <= AE);
    check("fwft.overflow", f_ovf, m_ovf);
    check("fwft.underflow", f_unf, m_unf);
    check("fwft.rd_valid", f_rd_valid, sz > 0);
    check("fwft.rd_data", f_rd_data, (sz > 0) ? m_q[0] : '0);
  endtask

  // One clock: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit fl = 0, input bit ce = 0, input bit rs = 0);
    wr_en = w; wr_data = d; rd_en = r; flush = fl; clr_err = ce; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic fill_to(input int n);
    while (m_q.size() < n) cycle(1, DW'($urandom), 0);
  endtask

  initial begin
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    @(negedge clk);

    // Reset, then idle.
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);

    // Fill 0x00..0x0F, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Overflow on full, clear it, drain, underflow on empty, clear it.
    fill_to(DEPTH);
    cycle(1, 8'hAA, 0);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'hAB, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    while (m_q.size() > 0) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    cycle(1, 8'h11, 1, 0, 1);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0, 0, 1);

    // Simultaneous write/read at count=5 across several pointer wraps.
    fill_to(5);
    for (int i = 0; i < 40; i++) cycle(1, DW'($urandom), 1);

    // Flush with same-cycle write and read at count=9.
    while (m_q.size() > 9) cycle(0, 8'h00, 1);
    fill_to(9);
    cycle(1, 8'hEE, 1, 1);
    cycle(1, 8'h5C, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // FWFT visibility of a single word, then reset mid-burst at count=7.
    cycle(1, 8'h3C, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    fill_to(7);
    cycle(1, 8'h77, 1, 0, 0, 1);
    cycle(0, 8'h00, 0);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      bit heavy_wr;
      heavy_wr = ((i / 100) % 2) == 0;
      cycle($urandom_range(99) < (heavy_wr ? 75 : 35),
            DW'($urandom),
            $urandom_range(99) < (heavy_wr ? 35 : 75),
            $urandom_range(99) < 2,
            $urandom_range(99) < 3,
            $urandom_range(999) < 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
